// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_reset_sequencer: PLL areset / lock qualification and SoC reset release  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module pll_reset_sequencer #(
  parameter int POR_HOLD_CYCLES     = 127,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               i_ext_clk_50m,
  input  logic                               i_btn_reset_n,
  input  logic                               i_pll_locked,
  output logic                               o_pll_areset,
  output logic                               o_soc_reset_n,
  output logic                               o_lock_fault,
  output logic [2:0]                         o_seq_state,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt,
  output logic [7:0]                         o_loss_cnt
);

  localparam int c_max_a   = (LOCK_TIMEOUT_CYCLES > POR_HOLD_CYCLES) ? LOCK_TIMEOUT_CYCLES : POR_HOLD_CYCLES;
  localparam int c_cnt_max = (c_max_a > LOCK_STABLE_CYCLES) ? c_max_a : LOCK_STABLE_CYCLES;
  localparam int CNT_W     = $clog2(c_cnt_max + 1);
  localparam int RTY_W     = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] c_por_last     = CNT_W'(POR_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] c_retry_last   = RTY_W'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    ST_POR_HOLD    = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_LOCK_STABLE = 3'd2,
    ST_RUN         = 3'd3,
    ST_FAULT       = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [RTY_W-1:0] r_retry, w_retry_next;
  logic [7:0]       r_loss, w_loss_next;
  logic             r_lock_meta, r_lock_s;
  logic             r_pll_areset, r_soc_reset_n, r_lock_fault;
  logic             w_areset_next, w_soc_next, w_fault_next;

  // PLL_LOCKED comes from the PLL's own domain; only r_lock_s feeds decisions.
  always_ff @(posedge i_ext_clk_50m or negedge i_btn_reset_n) begin
    if (!i_btn_reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge i_ext_clk_50m or negedge i_btn_reset_n) begin
    if (!i_btn_reset_n) begin
      r_state       <= ST_POR_HOLD;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_loss        <= '0;
      r_pll_areset  <= 1'b1;
      r_soc_reset_n <= 1'b0;
      r_lock_fault  <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_cnt_next;
      r_retry       <= w_retry_next;
      r_loss        <= w_loss_next;
      r_pll_areset  <= w_areset_next;
      r_soc_reset_n <= w_soc_next;
      r_lock_fault  <= w_fault_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_loss_next  = r_loss;
    case (r_state)
      ST_POR_HOLD: begin
        if (r_cnt == c_por_last) w_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (r_lock_s) begin
          w_next = ST_LOCK_STABLE;
        end else if (r_cnt == c_timeout_last) begin
          if (r_retry == c_retry_last) begin
            w_next = ST_FAULT;
          end else begin
            w_next       = ST_POR_HOLD;
            w_retry_next = r_retry + RTY_W'(1);
          end
        end
      end
      ST_LOCK_STABLE: begin
        if (!r_lock_s) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_cnt == c_stable_last) begin
          w_next       = ST_RUN;
          w_retry_next = '0;
        end
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_next = ST_POR_HOLD;
          if (r_loss != 8'hFF) w_loss_next = r_loss + 8'd1;
        end
      end
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_POR_HOLD;
    endcase

    // The counter only times POR_HOLD, WAIT_LOCK and LOCK_STABLE.
    if ((w_next != r_state) || (r_state == ST_RUN) || (r_state == ST_FAULT))
      w_cnt_next = '0;
    else
      w_cnt_next = r_cnt + CNT_W'(1);

    w_areset_next = (w_next == ST_POR_HOLD) || (w_next == ST_FAULT);
    w_soc_next    = (w_next == ST_RUN);
    w_fault_next  = (w_next == ST_FAULT);
  end

  assign o_pll_areset  = r_pll_areset;
  assign o_soc_reset_n = r_soc_reset_n;
  assign o_lock_fault  = r_lock_fault;
  assign o_seq_state   = r_state;
  assign o_retry_cnt   = r_retry;
  assign o_loss_cnt    = r_loss;

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Board-level reset and PLL bring-up sequencer at the top level, replacing the free-running power-up timer.
- Holds the SoC PLL in reset after power-up or a button reset, then waits for a stable PLL lock.
- Releases the SoC reset only after lock has been stable for a set time.
- Handles lock loss, lock timeout with bounded retries, and a sticky fault condition.
- Drives the SoC's PLL areset conduit and consumes its locked conduit.

Parameters:
- POR_HOLD_CYCLES, 127: cycles PLL_ARESET is held high on each POR_HOLD entry.
- LOCK_TIMEOUT_CYCLES, 500000: maximum cycles spent in WAIT_LOCK (10 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before SoC reset release.
- MAX_RETRIES, 3: number of lock timeouts that forces FAULT.

Ports:
- EXT_CLK_50M  in  1  sole clock, 50 MHz board oscillator.
- BTN_RESET_n  in  1  asynchronous active-low reset (push-button).
- PLL_LOCKED  in  1  PLL locked flag; asynchronous to EXT_CLK_50M.
- PLL_ARESET  out  1  active-high PLL reset.
- SOC_RESET_n  out  1  active-low SoC reset.
- LOCK_FAULT  out  1  sticky fault flag.
- SEQ_STATE  out  3  current state encoding.
- RETRY_CNT  out  2  lock-timeout retries used (clog2(MAX_RETRIES+1) bits).
- LOSS_CNT  out  8  saturating count of lock losses seen in RUN.

Behaviour:
- Reset: one clock domain; reset is asynchronous, active-low on BTN_RESET_n. All registers reset asynchronously; deassertion is sampled on EXT_CLK_50M.
- Reset values: state=POR_HOLD, PLL_ARESET=1, SOC_RESET_n=0, LOCK_FAULT=0, RETRY_CNT=0, LOSS_CNT=0, counter=0, synchronizer flops=0.
- PLL_LOCKED synchronization: two-flop synchronizer giving lock_s, 2-cycle latency. All FSM decisions use lock_s only.
- Outputs: all registered. SEQ_STATE encoding: POR_HOLD=0, WAIT_LOCK=1, LOCK_STABLE=2, RUN=3, FAULT=4.
- Shared counter: width clog2(max(LOCK_TIMEOUT_CYCLES, POR_HOLD_CYCLES, LOCK_STABLE_CYCLES)+1). Cleared on every state transition.
- POR_HOLD:
  - PLL_ARESET=1, SOC_RESET_n=0; counter increments each cycle.
  - When counter==POR_HOLD_CYCLES-1, go to WAIT_LOCK.
  - PLL_ARESET is therefore high for exactly POR_HOLD_CYCLES edges after reset release.
- WAIT_LOCK:
  - PLL_ARESET=0, SOC_RESET_n=0.
  - If lock_s=1, go to LOCK_STABLE.
  - Otherwise, if counter==LOCK_TIMEOUT_CYCLES-1:
    - if RETRY_CNT==MAX_RETRIES-1, go to FAULT;
    - else RETRY_CNT+1 and go to POR_HOLD.
  - If lock_s=1 and timeout occur in the same cycle, lock wins.
- LOCK_STABLE:
  - PLL_ARESET=0, SOC_RESET_n=0.
  - If lock_s=0, go to WAIT_LOCK (counter cleared; timeout restarts; RETRY_CNT unchanged).
  - If counter==LOCK_STABLE_CYCLES-1 with lock_s=1, go to RUN and clear RETRY_CNT.
- RUN:
  - SOC_RESET_n=1 from the first RUN cycle (registered with state).
  - If lock_s=0: SOC_RESET_n=0 on the next edge, LOSS_CNT+1 (saturates at 255), go to POR_HOLD.
  - Total lock-loss-to-reset latency: 3 cycles after PLL_LOCKED falls (2 synchronizer + 1 state register).
- FAULT:
  - PLL_ARESET=1, SOC_RESET_n=0, LOCK_FAULT=1.
  - Terminal state; exits only via BTN_RESET_n assertion.
- Glitch handling: a 1-cycle lock_s dropout in LOCK_STABLE restarts qualification; in RUN it triggers a full re-sequence. No extra filtering.
- Unused state encodings decode to POR_HOLD.

Test Plan:
(Parameters for all scenarios: POR_HOLD_CYCLES=8, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=4, MAX_RETRIES=3.)
- Nominal bring-up: release reset, PLL_LOCKED rises 5 cycles after PLL_ARESET falls -> PLL_ARESET falls at edge 8; SOC_RESET_n rises 2+1+4 edges after PLL_LOCKED rises; SEQ_STATE sequence 0,1,2,3; RETRY_CNT=0.
- Lock dropout during qualification: drop PLL_LOCKED for 1 cycle after 2 stable cycles -> state returns to 1 then 2; SOC_RESET_n stays 0 until 4 fresh consecutive lock_s-high cycles.
- Lock loss in RUN: PLL_LOCKED falls -> SOC_RESET_n=0 exactly 3 cycles later; LOSS_CNT=1; PLL_ARESET high 8 cycles; re-lock returns to RUN.
- Timeout/retry: PLL_LOCKED held 0 -> 3 timeouts of 20 cycles, RETRY_CNT 0->1->2, then FAULT: LOCK_FAULT=1, SEQ_STATE=4, PLL_ARESET=1. Raising PLL_LOCKED afterwards -> no change.
- Asynchronous reset mid-RUN: pulse BTN_RESET_n low between clock edges -> PLL_ARESET=1, SOC_RESET_n=0, LOCK_FAULT=0, LOSS_CNT=0 immediately, before the next edge; full sequence restarts.
- Saturation/simultaneity: force 260 lock losses -> LOSS_CNT=255. Lock_s rising on the WAIT_LOCK timeout cycle -> enters LOCK_STABLE, RETRY_CNT unchanged.
